// File: rtl/noc_mem_pkg.sv
// Shared definitions for the NoC-to-memory port adapter.
//   - Flit type codes carried in flit[FLIT_W-1 -: 2].
//   - Bit positions of the fields in a head flit payload.
//   - Request opcodes and the adapter FSM state encoding.
package noc_mem_pkg;

    localparam int unsigned NOC_DATA_W = 32;
    localparam int unsigned FLIT_W     = NOC_DATA_W + 2;

    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;
    localparam logic [1:0] FLIT_HT   = 2'b11;

    localparam int unsigned HEAD_OP_BIT   = 31;
    localparam int unsigned HEAD_LEN_MSB  = 27;
    localparam int unsigned HEAD_LEN_LSB  = 20;
    localparam int unsigned HEAD_SRC_MSB  = 19;
    localparam int unsigned HEAD_SRC_LSB  = 16;
    localparam int unsigned HEAD_MASK_MSB = 15;
    localparam int unsigned HEAD_MASK_LSB = 12;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdHdr,
        StRdIssue,
        StRdDrain,
        StDrop
    } state_e;

endpackage

// File: rtl/noc_mem_resp_fifo.sv
// Two-entry response FIFO for the NoC memory port adapter.
//   clk, reset_n  : clock, asynchronous active-low reset (storage cleared)
//   push_i/data   : write one entry; accepted when full only if popping too
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry
//   count_o       : occupancy 0..2
//   empty_o       : no entries held
module noc_mem_resp_fifo #(
    parameter int unsigned Width = 34
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             full, do_push, do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/noc_mem_port_adapter.sv
// NoC-to-memory endpoint adapter: turns router request packets into accesses
// on a single-port, byte-enabled, 1-cycle-latency data memory and returns
// read responses as packets.
//   clk, reset_n                : clock, asynchronous active-low reset
//   in_flit/in_valid/in_ready   : request flits from the router ejection port
//   out_flit/out_valid/out_ready: response flits to the router injection port
//   mem_*                       : memory slave strobe, address, lanes, data
//   busy                        : a packet is being processed
// Build option: define NOC_MEM_BYTE_MASK_EN to apply the head byte mask to
// write strobes (mask 0 means all lanes); otherwise writes use all lanes.
module noc_mem_port_adapter
    import noc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter logic [3:0]  NODE_ID = 4'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W+1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W+1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic              last_q, last_d;

    logic [1:0]        in_type;
    logic [DATA_W-1:0] payload;
    logic              in_rdy;
    logic [3:0]        wr_be;
    logic [DATA_W-1:0] rsp_hdr;

    logic              push, pop, fifo_empty;
    logic [DATA_W+1:0] push_data;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic              credit_ok;
    logic              unused_head;

    assign in_type = in_flit[DATA_W+1:DATA_W];
    assign payload = in_flit[DATA_W-1:0];

    // Hold in_ready low while reset is applied, not just after the first edge.
    assign in_ready = in_rdy & reset_n;
    assign busy     = (state_q != StIdle);

`ifdef NOC_MEM_BYTE_MASK_EN
    logic [3:0] mask_q, mask_d;
    assign wr_be       = (mask_q == 4'h0) ? 4'hF : mask_q;
    assign unused_head = ^{payload[30:28], payload[HEAD_SRC_MSB:HEAD_SRC_LSB]};
`else
    assign wr_be       = 4'hF;
    assign unused_head = ^{payload[30:28], payload[HEAD_SRC_MSB:HEAD_SRC_LSB],
                           payload[HEAD_MASK_MSB:HEAD_MASK_LSB]};
`endif

    always_comb begin
        rsp_hdr                            = '0;
        rsp_hdr[HEAD_OP_BIT]               = OP_READ;
        rsp_hdr[HEAD_LEN_MSB:HEAD_LEN_LSB] = len_q;
        rsp_hdr[HEAD_SRC_MSB:HEAD_SRC_LSB] = NODE_ID;
        rsp_hdr[ADDR_W-1:0]                = addr_q;
    end

    // Read credit: words already queued or in flight, less the one leaving
    // this cycle, must leave room for the word this strobe will return.
    assign pop       = out_valid & out_ready;
    assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (occ < 3'd2);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        inflight_d     = 1'b0;
        last_d         = last_q;
        in_rdy         = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = 4'h0;
        mem_writedata  = '0;
        push           = 1'b0;
        push_data      = '0;
`ifdef NOC_MEM_BYTE_MASK_EN
        mask_d         = mask_q;
`endif

        // Read data returned for last cycle's strobe; room is guaranteed.
        if (inflight_q) begin
            push      = 1'b1;
            push_data = {(last_q ? FLIT_TAIL : FLIT_BODY), mem_readdata};
        end

        case (state_q)
            StIdle: begin
                in_rdy = 1'b1;
                if (in_valid && (in_type == FLIT_HEAD || in_type == FLIT_HT)) begin
                    addr_d = payload[ADDR_W-1:0];
                    len_d  = payload[HEAD_LEN_MSB:HEAD_LEN_LSB];
                    cnt_d  = 8'd0;
`ifdef NOC_MEM_BYTE_MASK_EN
                    mask_d = payload[HEAD_MASK_MSB:HEAD_MASK_LSB];
`endif
                    if (payload[HEAD_OP_BIT] == OP_READ) begin
                        state_d = StRdHdr;
                    end else if (in_type == FLIT_HEAD) begin
                        state_d = StWr;
                    end
                end
            end

            StWr: begin
                in_rdy = 1'b1;
                if (in_valid && (in_type == FLIT_BODY || in_type == FLIT_TAIL)) begin
                    mem_chipselect = 1'b1;
                    mem_write      = 1'b1;
                    mem_address    = addr_q;
                    mem_byteenable = wr_be;
                    mem_writedata  = payload;
                    addr_d         = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_d          = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d = (in_type == FLIT_TAIL) ? StIdle : StDrop;
                    end else if (in_type == FLIT_TAIL) begin
                        state_d = StIdle;
                    end
                end
            end

            StDrop: begin
                in_rdy = 1'b1;
                if (in_valid && in_type == FLIT_TAIL) begin
                    state_d = StIdle;
                end
            end

            StRdHdr: begin
                push      = 1'b1;
                push_data = {FLIT_HEAD, rsp_hdr};
                state_d   = StRdIssue;
            end

            StRdIssue: begin
                if (credit_ok) begin
                    mem_chipselect = 1'b1;
                    mem_address    = addr_q;
                    mem_byteenable = 4'hF;
                    inflight_d     = 1'b1;
                    last_d         = (cnt_q == len_q);
                    addr_d         = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_d          = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d = StRdDrain;
                    end
                end
            end

            StRdDrain: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
`ifdef NOC_MEM_BYTE_MASK_EN
            mask_q     <= 4'h0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            last_q     <= last_d;
`ifdef NOC_MEM_BYTE_MASK_EN
            mask_q     <= mask_d;
`endif
        end
    end

    noc_mem_resp_fifo #(
        .Width (DATA_W + 2)
    ) u_resp_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (out_flit),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;

endmodule
